// File: rtl/dec_pkg.sv
`default_nettype none
// ============================================================================
// Module  : dec_pkg
// Purpose : Shared types, widths and helpers for the break-before-make decoder.
// Revision: 1.0 - initial release
// ============================================================================
package dec_pkg;

    localparam int DEC_IN_W  = 3;
    localparam int DEC_OUT_W = 2 ** DEC_IN_W;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GAP   = 2'd1,
        S_DRIVE = 2'd2,
        S_HOLD  = 2'd3
    } bbm_state_t;

    function automatic logic [DEC_OUT_W-1:0] onehot(input logic [DEC_IN_W-1:0] c);
        return DEC_OUT_W'(1) << c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bbm_timer.sv
`default_nettype none
// ============================================================================
// Module  : bbm_timer
// Purpose : Loadable saturating down-counter; done flags the last counted cycle.
// Revision: 1.0 - initial release
// ============================================================================
module bbm_timer #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         done
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - W'(1);
        end
    end

    // A phase loaded with N ends after its N-th cycle, when the count reads 1.
    assign done = (cnt <= W'(1));

endmodule
`default_nettype wire

// File: rtl/decoder_3_8_bbm.sv
`default_nettype none
// ============================================================================
// Module  : decoder_3_8_bbm
// Purpose : Registered 3-to-8 one-hot select driver with break-before-make gap
//           and minimum dwell per selection.
// Revision: 1.0 - initial release
// ============================================================================
module decoder_3_8_bbm
    import dec_pkg::*;
#(
    parameter int IN_W  = DEC_IN_W,
    parameter int GAP   = 2,
    parameter int DWELL = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [IN_W-1:0]       code,
    input  logic                  clr,
    output logic [(2**IN_W)-1:0]  o,
    output logic                  busy
);

    localparam int OUT_W = 2 ** IN_W;
    localparam int MAX_T = (GAP > DWELL) ? GAP : DWELL;
    localparam int TW    = (MAX_T < 1) ? 1 : $clog2(MAX_T + 1);

    bbm_state_t      state;
    logic [IN_W-1:0] cur_q;
    logic [IN_W-1:0] nxt_q;

    logic            accept;
    logic            to_gap;
    logic            to_drive;
    logic            t_load;
    logic            t_en;
    logic            t_done;
    logic [TW-1:0]   t_val;

    function automatic logic [OUT_W-1:0] sel(input logic [IN_W-1:0] c);
        return OUT_W'(1) << c;
    endfunction

    assign in_ready = ((state == S_IDLE) || (state == S_HOLD)) && !rst;
    // clr takes the slot whenever the block is ready, so it also blocks an accept.
    assign accept   = in_ready && in_valid && !clr;

    always_comb begin
        to_gap   = 1'b0;
        to_drive = 1'b0;
        case (state)
            S_IDLE:  to_drive = accept;
            S_GAP:   to_drive = t_done;
            S_HOLD: begin
                if (accept && (code != cur_q)) begin
                    if (GAP > 0) to_gap   = 1'b1;
                    else         to_drive = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign t_load = to_gap || to_drive;
    assign t_val  = to_gap ? TW'(GAP) : TW'(DWELL);
    assign t_en   = (state == S_GAP) || (state == S_DRIVE);

    bbm_timer #(
        .W (TW)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (t_load),
        .load_val (t_val),
        .en       (t_en),
        .done     (t_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            cur_q <= '0;
            nxt_q <= '0;
            o     <= '0;
            busy  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (to_drive) begin
                        state <= S_DRIVE;
                        cur_q <= code;
                        o     <= sel(code);
                        busy  <= 1'b1;
                    end
                end
                S_GAP: begin
                    if (to_drive) begin
                        state <= S_DRIVE;
                        cur_q <= nxt_q;
                        o     <= sel(nxt_q);
                    end
                end
                S_DRIVE: begin
                    if (t_done) begin
                        state <= S_HOLD;
                        busy  <= 1'b0;
                    end
                end
                S_HOLD: begin
                    if (clr) begin
                        state <= S_IDLE;
                        o     <= '0;
                    end else if (to_gap) begin
                        state <= S_GAP;
                        nxt_q <= code;
                        o     <= '0;
                        busy  <= 1'b1;
                    end else if (to_drive) begin
                        state <= S_DRIVE;
                        cur_q <= code;
                        o     <= sel(code);
                        busy  <= 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    o     <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_decoder_3_8_bbm.sv
`default_nettype none
// ============================================================================
// Module  : tb_decoder_3_8_bbm
// Purpose : Self-checking bench: directed table, random vs. reference model,
//           and a GAP=0 instance for direct switching and reset mid-drive.
// Revision: 1.0 - initial release
// ============================================================================
module tb_decoder_3_8_bbm;

    localparam int GAP_P   = 2;
    localparam int DWELL_P = 4;

    logic       clk = 1'b0;
    logic       rst, in_valid, clr, in_ready, busy;
    logic [2:0] code;
    logic [7:0] o;
    logic       rst_z, in_valid_z, clr_z, in_ready_z, busy_z;
    logic [2:0] code_z;
    logic [7:0] o_z;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    decoder_3_8_bbm #(.IN_W(3), .GAP(GAP_P), .DWELL(DWELL_P)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .code(code), .clr(clr), .o(o), .busy(busy)
    );

    decoder_3_8_bbm #(.IN_W(3), .GAP(0), .DWELL(DWELL_P)) dut_z (
        .clk(clk), .rst(rst_z), .in_valid(in_valid_z), .in_ready(in_ready_z),
        .code(code_z), .clr(clr_z), .o(o_z), .busy(busy_z)
    );

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Safety properties checked on every cycle for both instances.
    always @(negedge clk) begin
        chk("onehot_main", int'($countones(o) > 1), 0);
        chk("busy_ready_main", int'(busy && in_ready), 0);
        chk("onehot_gap0", int'($countones(o_z) > 1), 0);
        chk("busy_ready_gap0", int'(busy_z && in_ready_z), 0);
    end

    typedef struct {
        bit         r;
        bit         v;
        bit         c;
        logic [2:0] cd;
        logic [7:0] eo;
        bit         eb;
        bit         er;
    } vec_t;

    function automatic vec_t mk(bit r, bit v, bit c, logic [2:0] cd,
                                logic [7:0] eo, bit eb, bit er);
        vec_t t;
        t.r = r; t.v = v; t.c = c; t.cd = cd; t.eo = eo; t.eb = eb; t.er = er;
        return t;
    endfunction

    // Reference model: a queue of future output values, filled when a request is accepted.
    logic [7:0] mq[$];
    logic [7:0] m_steady = 8'h00;
    logic [7:0] m_o      = 8'h00;
    bit         m_busy   = 1'b0;

    task automatic model_step(input bit r, input bit v, input bit c, input logic [2:0] cd);
        logic [7:0] nv;
        nv = 8'h01 << cd;
        if (r) begin
            mq.delete();
            m_steady = 8'h00; m_o = 8'h00; m_busy = 1'b0;
        end else if (m_busy) begin
            if (mq.size() > 0) begin
                m_o = mq.pop_front();
            end else begin
                m_o = m_steady; m_busy = 1'b0;
            end
        end else begin
            if (c) begin
                m_steady = 8'h00;
            end else if (v && (nv != m_steady)) begin
                if (m_steady != 8'h00)
                    for (int k = 0; k < GAP_P; k++) mq.push_back(8'h00);
                for (int k = 0; k < DWELL_P; k++) mq.push_back(nv);
                m_steady = nv;
            end
            if (mq.size() > 0) begin
                m_o = mq.pop_front(); m_busy = 1'b1;
            end else begin
                m_o = m_steady;
            end
        end
    endtask

    vec_t tbl[29];

    initial begin
        rst = 1'b1; in_valid = 1'b0; clr = 1'b0; code = 3'd0;
        rst_z = 1'b1; in_valid_z = 1'b0; clr_z = 1'b0; code_z = 3'd0;

        tbl[0]  = mk(1, 0, 0, 0, 8'h00, 0, 0);
        tbl[1]  = mk(1, 0, 0, 0, 8'h00, 0, 0);
        tbl[2]  = mk(1, 0, 0, 0, 8'h00, 0, 0);
        tbl[3]  = mk(0, 0, 0, 0, 8'h00, 0, 1);
        tbl[4]  = mk(0, 1, 0, 5, 8'h20, 1, 0);
        tbl[5]  = mk(0, 0, 0, 0, 8'h20, 1, 0);
        tbl[6]  = mk(0, 0, 0, 0, 8'h20, 1, 0);
        tbl[7]  = mk(0, 0, 0, 0, 8'h20, 1, 0);
        tbl[8]  = mk(0, 0, 0, 0, 8'h20, 0, 1);
        tbl[9]  = mk(0, 1, 0, 0, 8'h00, 1, 0);
        tbl[10] = mk(0, 0, 0, 0, 8'h00, 1, 0);
        tbl[11] = mk(0, 0, 0, 0, 8'h01, 1, 0);
        tbl[12] = mk(0, 0, 0, 0, 8'h01, 1, 0);
        tbl[13] = mk(0, 0, 0, 0, 8'h01, 1, 0);
        tbl[14] = mk(0, 0, 0, 0, 8'h01, 1, 0);
        tbl[15] = mk(0, 0, 0, 0, 8'h01, 0, 1);
        tbl[16] = mk(0, 1, 0, 0, 8'h01, 0, 1);
        tbl[17] = mk(0, 0, 0, 0, 8'h01, 0, 1);
        tbl[18] = mk(0, 1, 1, 7, 8'h00, 0, 1);
        tbl[19] = mk(0, 0, 0, 0, 8'h00, 0, 1);
        tbl[20] = mk(0, 1, 0, 3, 8'h08, 1, 0);
        tbl[21] = mk(0, 1, 0, 6, 8'h08, 1, 0);
        tbl[22] = mk(0, 0, 0, 0, 8'h08, 1, 0);
        tbl[23] = mk(0, 0, 0, 0, 8'h08, 1, 0);
        tbl[24] = mk(0, 0, 0, 0, 8'h08, 0, 1);
        tbl[25] = mk(0, 1, 0, 2, 8'h00, 1, 0);
        tbl[26] = mk(1, 0, 0, 0, 8'h00, 0, 0);
        tbl[27] = mk(0, 0, 0, 0, 8'h00, 0, 1);
        tbl[28] = mk(0, 0, 0, 0, 8'h00, 0, 1);

        for (int i = 0; i < 29; i++) begin
            rst = tbl[i].r; in_valid = tbl[i].v; clr = tbl[i].c; code = tbl[i].cd;
            @(posedge clk); #1;
            chk($sformatf("vec%0d_o", i), int'(o), int'(tbl[i].eo));
            chk($sformatf("vec%0d_busy", i), int'(busy), int'(tbl[i].eb));
            chk($sformatf("vec%0d_ready", i), int'(in_ready), int'(tbl[i].er));
        end

        for (int i = 0; i < 1500; i++) begin
            rst      = (i < 2) || ($urandom_range(0, 149) == 0);
            in_valid = $urandom_range(0, 1);
            clr      = ($urandom_range(0, 9) == 0);
            code     = 3'($urandom_range(0, 7));
            model_step(rst, in_valid, clr, code);
            @(posedge clk); #1;
            chk("rand_o", int'(o), int'(m_o));
            chk("rand_busy", int'(busy), int'(m_busy));
            chk("rand_ready", int'(in_ready), int'(!m_busy && !rst));
        end
        rst = 1'b0; in_valid = 1'b0; clr = 1'b0;

        rst_z = 1'b0;
        @(posedge clk); #1;
        chk("g0_idle_ready", int'(in_ready_z), 1);
        in_valid_z = 1'b1; code_z = 3'd1;
        @(posedge clk); #1;
        in_valid_z = 1'b0;
        chk("g0_first_o", int'(o_z), 8'h02);
        repeat (3) @(posedge clk);
        #1;
        chk("g0_dwell_busy", int'(busy_z), 1);
        @(posedge clk); #1;
        chk("g0_hold_ready", int'(in_ready_z), 1);
        chk("g0_hold_o", int'(o_z), 8'h02);
        in_valid_z = 1'b1; code_z = 3'd6;
        @(posedge clk); #1;
        in_valid_z = 1'b0;
        chk("g0_direct_o", int'(o_z), 8'h40);
        chk("g0_direct_busy", int'(busy_z), 1);
        @(posedge clk); #1;
        rst_z = 1'b1;
        @(posedge clk); #1;
        chk("g0_rst_o", int'(o_z), 8'h00);
        chk("g0_rst_ready", int'(in_ready_z), 0);
        rst_z = 1'b0;
        @(posedge clk); #1;
        chk("g0_after_rst_o", int'(o_z), 8'h00);
        chk("g0_after_rst_ready", int'(in_ready_z), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
